timer_sequencer: RTL and testbench

- Avalon-MM master that programs and services the 16-bit-bus interval timer peripheral (period L/H, control, status, snapshot registers) on behalf of one hardware client.
- Converts simple start/stop requests and a 32-bit period into the timer register write sequence.
- Clears the timer status on every irq, and reports a tick pulse plus a running tick count.
- Sits between a hardware scheduler/client and the timer slave; the CPU does not own the timer when this block is used.

---
 rtl/timer_sequencer.sv | 165 ++++++++++++++++
 tb/tb_timer_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sequencer.sv
// Avalon-MM master that programs and services a 16-bit-bus interval timer for one hardware client.
// Optional snapshot readback of the live counter is enabled with `define TIMER_SEQ_SNAPSHOT_EN.
module timer_sequencer #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              done,
    output logic [2:0]        t_address,
    output logic              t_chipselect,
    output logic              t_write_n,
    output logic [15:0]       t_writedata,
    input  logic [15:0]       t_readdata,
`ifdef TIMER_SEQ_SNAPSHOT_EN
    input  logic              snap_req,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
`endif
    input  logic              t_irq
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_PL    = 4'd1;
    localparam logic [3:0] S_WR_PH    = 4'd2;
    localparam logic [3:0] S_WR_CTRL  = 4'd3;
    localparam logic [3:0] S_RUN      = 4'd4;
    localparam logic [3:0] S_CLR_ST   = 4'd5;
    localparam logic [3:0] S_WR_STOP  = 4'd6;
`ifdef TIMER_SEQ_SNAPSHOT_EN
    localparam logic [3:0] S_SNAP_WR  = 4'd7;
    localparam logic [3:0] S_SNAP_RDL = 4'd8;
    localparam logic [3:0] S_SNAP_RDH = 4'd9;
    localparam logic [3:0] S_SNAP_CAP = 4'd10;
`endif

    logic [3:0]        state;
    logic [3:0]        next_state;
    logic [31:0]       period_q;
    logic              cont_q;
    logic              stop_pend;
    logic              stop_now;
    logic [TICK_W-1:0] tick_count_q;

    assign stop_now = stop_pend | cfg_stop;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (cfg_start) next_state = S_WR_PL;
            S_WR_PL:   next_state = S_WR_PH;
            S_WR_PH:   next_state = S_WR_CTRL;
            S_WR_CTRL: next_state = S_RUN;
            S_RUN: begin
                if (t_irq)
                    next_state = S_CLR_ST;
                else if (stop_now)
                    next_state = S_WR_STOP;
`ifdef TIMER_SEQ_SNAPSHOT_EN
                else if (snap_req)
                    next_state = S_SNAP_WR;
`endif
            end
            S_CLR_ST: begin
                if (stop_now)
                    next_state = S_WR_STOP;
                else if (!cont_q)
                    next_state = S_IDLE;
                else
                    next_state = S_RUN;
            end
            S_WR_STOP: next_state = S_IDLE;
`ifdef TIMER_SEQ_SNAPSHOT_EN
            S_SNAP_WR:  next_state = S_SNAP_RDL;
            S_SNAP_RDL: next_state = S_SNAP_RDH;
            S_SNAP_RDH: next_state = S_SNAP_CAP;
            S_SNAP_CAP: next_state = S_RUN;
`endif
            default:   next_state = S_IDLE;
        endcase
    end

    // Bus signals are a pure decode of the state; each write lasts exactly one cycle.
    always_comb begin
        t_chipselect = 1'b0;
        t_write_n    = 1'b1;
        t_address    = 3'd0;
        t_writedata  = 16'h0000;
        case (state)
            S_WR_PL:   begin t_chipselect = 1'b1; t_write_n = 1'b0; t_address = 3'd2; t_writedata = period_q[15:0]; end
            S_WR_PH:   begin t_chipselect = 1'b1; t_write_n = 1'b0; t_address = 3'd3; t_writedata = period_q[31:16]; end
            S_WR_CTRL: begin t_chipselect = 1'b1; t_write_n = 1'b0; t_address = 3'd1; t_writedata = {12'h000, 1'b0, 1'b1, cont_q, 1'b1}; end
            S_CLR_ST:  begin t_chipselect = 1'b1; t_write_n = 1'b0; t_address = 3'd0; end
            S_WR_STOP: begin t_chipselect = 1'b1; t_write_n = 1'b0; t_address = 3'd1; t_writedata = 16'h0008; end
`ifdef TIMER_SEQ_SNAPSHOT_EN
            S_SNAP_WR:  begin t_chipselect = 1'b1; t_write_n = 1'b0; t_address = 3'd4; end
            S_SNAP_RDL: begin t_chipselect = 1'b1; t_address = 3'd4; end
            S_SNAP_RDH: begin t_chipselect = 1'b1; t_address = 3'd5; end
`endif
            default:   ;
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign tick       = (state == S_CLR_ST);
    assign done       = (state == S_CLR_ST) && !stop_now && !cont_q;
    assign tick_count = tick_count_q;
`ifdef TIMER_SEQ_SNAPSHOT_EN
    assign running    = (state == S_RUN) || (state == S_CLR_ST) || (state == S_SNAP_WR) ||
                        (state == S_SNAP_RDL) || (state == S_SNAP_RDH) || (state == S_SNAP_CAP);
`else
    assign running    = (state == S_RUN) || (state == S_CLR_ST);
`endif

    // A zero period is clamped to 1 so the timer cannot re-trigger every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            period_q     <= 32'd0;
            cont_q       <= 1'b0;
            stop_pend    <= 1'b0;
            tick_count_q <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && cfg_start) begin
                period_q     <= (cfg_period == 32'd0) ? 32'd1 : cfg_period;
                cont_q       <= cfg_continuous;
                tick_count_q <= '0;
            end else if (state == S_CLR_ST) begin
                tick_count_q <= tick_count_q + 1'b1;
            end
            if (next_state == S_IDLE)
                stop_pend <= 1'b0;
            else if (state != S_IDLE && cfg_stop)
                stop_pend <= 1'b1;
        end
    end

`ifdef TIMER_SEQ_SNAPSHOT_EN
    logic [15:0] snap_lo;

    // Readdata lags the address by one cycle, so each half is taken in the following state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_lo    <= 16'h0000;
            snap_value <= 32'd0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= (state == S_SNAP_CAP);
            if (state == S_SNAP_RDH)
                snap_lo <= t_readdata;
            if (state == S_SNAP_CAP)
                snap_value <= {t_readdata, snap_lo};
        end
    end
`endif

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: a table of per-cycle vectors plus hand-written
// sequences for asynchronous reset and tick_count wrap with a small timer model.
module tb_timer_sequencer;

    localparam int TW = 4;

    logic          clk;
    logic          reset_n;
    logic          cfg_start;
    logic          cfg_stop;
    logic [31:0]   cfg_period;
    logic          cfg_continuous;
    logic          busy;
    logic          running;
    logic          tick;
    logic [TW-1:0] tick_count;
    logic          done;
    logic [2:0]    t_address;
    logic          t_chipselect;
    logic          t_write_n;
    logic [15:0]   t_writedata;
    logic [15:0]   t_readdata;
    logic          t_irq;

    int tests_run;
    int tests_failed;

    timer_sequencer #(.TICK_W(TW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .busy           (busy),
        .running        (running),
        .tick           (tick),
        .tick_count     (tick_count),
        .done           (done),
        .t_address      (t_address),
        .t_chipselect   (t_chipselect),
        .t_write_n      (t_write_n),
        .t_writedata    (t_writedata),
        .t_readdata     (t_readdata),
        .t_irq          (t_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic          stop;
        logic [31:0]   period;
        logic          cont;
        logic          irq;
        logic          busy;
        logic          running;
        logic          tick;
        logic          done;
        logic          cs;
        logic          write_n;
        logic [2:0]    addr;
        logic [15:0]   wdata;
        logic [TW-1:0] count;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic sp, input logic [31:0] per, input logic ct,
                                input logic irq, input logic bz, input logic rn, input logic tk,
                                input logic dn, input logic cs, input logic wn, input logic [2:0] ad,
                                input logic [15:0] wd, input logic [TW-1:0] cnt);
        vec_t v;
        v.start = st; v.stop = sp; v.period = per; v.cont = ct; v.irq = irq;
        v.busy = bz; v.running = rn; v.tick = tk; v.done = dn; v.cs = cs; v.write_n = wn;
        v.addr = ad; v.wdata = wd; v.count = cnt;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle's inputs just after the falling edge, then samples the outputs.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        cfg_start      = v.start;
        cfg_stop       = v.stop;
        cfg_period     = v.period;
        cfg_continuous = v.cont;
        t_irq          = v.irq;
        #1;
    endtask

    function automatic logic [31:0] pack_ctl(input logic bz, input logic rn, input logic tk, input logic dn,
                                             input logic cs, input logic wn, input logic [2:0] ad,
                                             input logic [15:0] wd);
        return {7'd0, bz, rn, tk, dn, cs, wn, ad, wd};
    endfunction

    initial begin
        int ticks_seen;
        int clr_writes;
        int timer_cnt;
        bit armed;
        int budget;

        tests_run = 0;
        tests_failed = 0;
        reset_n = 1'b0;
        cfg_start = 1'b0;
        cfg_stop = 1'b0;
        cfg_period = 32'd0;
        cfg_continuous = 1'b0;
        t_readdata = 16'h0000;
        t_irq = 1'b0;

        // Continuous run: period 0x186A0, second start while busy, irq and stop together
        add(1,0,32'h000186A0,1,0, 0,0,0,0,0,1,3'd0,16'h0000,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd2,16'h86A0,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd3,16'h0001,0);
        add(1,0,32'h00000003,0,0, 1,0,0,0,1,0,3'd1,16'h0007,0);
        add(0,0,32'h0,0,0,        1,1,0,0,0,1,3'd0,16'h0000,0);
        add(0,0,32'h0,0,1,        1,1,0,0,0,1,3'd0,16'h0000,0);
        add(0,0,32'h0,0,1,        1,1,1,0,1,0,3'd0,16'h0000,0);
        add(0,0,32'h0,0,0,        1,1,0,0,0,1,3'd0,16'h0000,1);
        add(0,0,32'h0,0,1,        1,1,0,0,0,1,3'd0,16'h0000,1);
        add(0,0,32'h0,0,1,        1,1,1,0,1,0,3'd0,16'h0000,1);
        add(0,1,32'h0,0,1,        1,1,0,0,0,1,3'd0,16'h0000,2);
        add(0,0,32'h0,0,1,        1,1,1,0,1,0,3'd0,16'h0000,2);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd1,16'h0008,3);
        add(0,0,32'h0,0,0,        0,0,0,0,0,1,3'd0,16'h0000,3);
        // One-shot with period 0 clamped to 1: tick and done together
        add(1,0,32'h0,0,0,        0,0,0,0,0,1,3'd0,16'h0000,3);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd2,16'h0001,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd3,16'h0000,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd1,16'h0005,0);
        add(0,0,32'h0,0,1,        1,1,0,0,0,1,3'd0,16'h0000,0);
        add(0,0,32'h0,0,1,        1,1,1,1,1,0,3'd0,16'h0000,0);
        add(0,0,32'h0,0,0,        0,0,0,0,0,1,3'd0,16'h0000,1);
        // Stop during WR_PH is honoured right after RUN; stop in IDLE ignored
        add(1,0,32'h00000004,1,0, 0,0,0,0,0,1,3'd0,16'h0000,1);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd2,16'h0004,0);
        add(0,1,32'h0,0,0,        1,0,0,0,1,0,3'd3,16'h0000,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd1,16'h0007,0);
        add(0,0,32'h0,0,0,        1,1,0,0,0,1,3'd0,16'h0000,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd1,16'h0008,0);
        add(0,1,32'h0,0,0,        0,0,0,0,0,1,3'd0,16'h0000,0);
        add(0,0,32'h0,0,0,        0,0,0,0,0,1,3'd0,16'h0000,0);
        // Plain stop in RUN, split period halves
        add(1,0,32'h00050005,0,0, 0,0,0,0,0,1,3'd0,16'h0000,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd2,16'h0005,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd3,16'h0005,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd1,16'h0005,0);
        add(0,1,32'h0,0,0,        1,1,0,0,0,1,3'd0,16'h0000,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd1,16'h0008,0);
        add(0,0,32'h0,0,0,        0,0,0,0,0,1,3'd0,16'h0000,0);
        // One-shot with stop in CLR_ST: tick but no done, then WR_STOP
        add(1,0,32'h00000002,0,0, 0,0,0,0,0,1,3'd0,16'h0000,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd2,16'h0002,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd3,16'h0000,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd1,16'h0005,0);
        add(0,0,32'h0,0,1,        1,1,0,0,0,1,3'd0,16'h0000,0);
        add(0,1,32'h0,0,1,        1,1,1,0,1,0,3'd0,16'h0000,0);
        add(0,0,32'h0,0,0,        1,0,0,0,1,0,3'd1,16'h0008,1);
        add(0,0,32'h0,0,0,        0,0,0,0,0,1,3'd0,16'h0000,1);

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset ctl", pack_ctl(busy, running, tick, done, t_chipselect, t_write_n, t_address, t_writedata),
                    pack_ctl(0,0,0,0,0,1,3'd0,16'h0000));
        checkOutput("reset count", 32'(tick_count), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d ctl", i),
                        pack_ctl(busy, running, tick, done, t_chipselect, t_write_n, t_address, t_writedata),
                        pack_ctl(vecs[i].busy, vecs[i].running, vecs[i].tick, vecs[i].done,
                                 vecs[i].cs, vecs[i].write_n, vecs[i].addr, vecs[i].wdata));
            checkOutput($sformatf("vec%0d count", i), 32'(tick_count), 32'(vecs[i].count));
        end

        // Asynchronous reset in the middle of the register write sequence
        @(negedge clk);
        cfg_start = 1'b1; cfg_period = 32'h00001234; cfg_continuous = 1'b1; t_irq = 1'b0; cfg_stop = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("midseq addr", 32'(t_address), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset ctl", pack_ctl(busy, running, tick, done, t_chipselect, t_write_n, t_address, t_writedata),
                    pack_ctl(0,0,0,0,0,1,3'd0,16'h0000));
        @(negedge clk);
        reset_n = 1'b1;

        // Continuous run against a simple timer model until tick_count wraps past 2^TW
        @(negedge clk);
        cfg_start = 1'b1; cfg_period = 32'd9; cfg_continuous = 1'b1;
        ticks_seen = 0; clr_writes = 0; timer_cnt = 0; armed = 0; budget = 0;
        while (ticks_seen < 17 && budget < 2000) begin
            @(negedge clk);
            cfg_start = 1'b0;
            #1;
            budget++;
            if (tick) ticks_seen++;
            if (t_chipselect && !t_write_n && t_address == 3'd1 && t_writedata[2]) begin
                armed = 1; timer_cnt = 9;
            end else if (t_chipselect && !t_write_n && t_address == 3'd0) begin
                clr_writes++;
                t_irq = 1'b0;
            end else if (armed && !t_irq) begin
                if (timer_cnt == 0) begin
                    t_irq = 1'b1;
                    timer_cnt = 9;
                end else begin
                    timer_cnt--;
                end
            end
        end
        checkOutput("wrap ticks", 32'(ticks_seen), 32'd17);
        checkOutput("wrap status writes", 32'(clr_writes), 32'd17);
        @(negedge clk);
        #1;
        checkOutput("wrap tick_count", 32'(tick_count), 32'd1);
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        budget = 0;
        while (busy && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        #1;
        checkOutput("stop after wrap busy", 32'(busy), 32'd0);
        checkOutput("stop after wrap count", 32'(tick_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
